// File: rtl/dest_switching_pkg.sv
// Shared constants for the destination-switching layer: word layout,
// default sizes and arbiter state encoding.
package dest_switching_pkg;

  localparam int DATA_SIZE_DEF  = 10;
  localparam int FIFO_DEPTH_DEF = 4;

  localparam int CLASS_BIT = DATA_SIZE_DEF - 1;
  localparam int DEST_BIT  = DATA_SIZE_DEF - 2;

  localparam logic [0:0] PRIO_HI = 1'b0;
  localparam logic [0:0] PRIO_LO = 1'b1;

endpackage

// File: rtl/dest_switching_if.sv
// Upstream class-FIFO heads and downstream destination-FIFO ports.
// master = surrounding dataflow, slave = dest_switching.
interface dest_switching_if #(
  parameter int DATA_SIZE = 10
);
  logic [DATA_SIZE-1:0] in0;
  logic                 in0_empty;
  logic                 in0_pop;
  logic [DATA_SIZE-1:0] in1;
  logic                 in1_empty;
  logic                 in1_pop;
  logic [DATA_SIZE-1:0] out0;
  logic [DATA_SIZE-1:0] out1;
  logic                 pop0;
  logic                 pop1;
  logic                 empty0;
  logic                 empty1;
  logic                 full0;
  logic                 full1;
  logic                 almost_full0;
  logic                 almost_full1;
  logic                 almost_empty0;
  logic                 almost_empty1;
  logic                 Error;

  modport master (
    output in0, in0_empty, in1, in1_empty, pop0, pop1,
    input  in0_pop, in1_pop, out0, out1, empty0, empty1, full0, full1,
           almost_full0, almost_full1, almost_empty0, almost_empty1, Error
  );

  modport slave (
    input  in0, in0_empty, in1, in1_empty, pop0, pop1,
    output in0_pop, in1_pop, out0, out1, empty0, empty1, full0, full1,
           almost_full0, almost_full1, almost_empty0, almost_empty1, Error
  );
endinterface

// File: rtl/dest_switching_fifo.sv
// Show-ahead synchronous FIFO with occupancy flags; err pulses when a pop
// arrives while empty (that pop is ignored).
module dest_fifo
  import dest_switching_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int DEPTH     = FIFO_DEPTH_DEF,
  parameter int AF_THRESH = 3,
  parameter int AE_THRESH = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [DATA_SIZE-1:0] din,
  input  logic                 pop,
  output logic [DATA_SIZE-1:0] dout,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic                 do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign err     = pop & empty;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; a zero count hides stale words.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign empty        = (count == '0);
  assign full         = (count == CW'(DEPTH));
  assign almost_full  = (count >= CW'(AF_THRESH));
  assign almost_empty = (count <= CW'(AE_THRESH));
  assign dout         = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/dest_switching.sv
// Weighted round-robin between the class-0/class-1 FIFO heads (favouring
// class 1), routing each granted word into the FIFO named by its dest bit.
module dest_switching
  import dest_switching_pkg::*;
#(
  parameter int DATA_SIZE  = DATA_SIZE_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int AF_THRESH  = 3,
  parameter int AE_THRESH  = 1,
  parameter int WEIGHT     = 3
) (
  input logic             clk,
  input logic             reset,
  dest_switching_if.slave bus
);
  // Destination bit sits directly below the class bit, at any word width.
  localparam int              DEST = DATA_SIZE - 1 - (CLASS_BIT - DEST_BIT);
  localparam int              CW   = $clog2(WEIGHT + 1);
  localparam logic [CW-1:0]   WMAX = CW'(WEIGHT);

  logic [0:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 dest0, dest1, elig0, elig1, grant0, grant1;
  logic                 full_f0, full_f1, err_f0, err_f1, err_q;
  logic                 push_f0, push_f1;
  logic [DATA_SIZE-1:0] din_f;

  assign dest0 = bus.in0[DEST];
  assign dest1 = bus.in1[DEST];
  // Registered full only: a same-cycle downstream pop never frees space.
  assign elig0 = ~bus.in0_empty & ~(dest0 ? full_f1 : full_f0);
  assign elig1 = ~bus.in1_empty & ~(dest1 ? full_f1 : full_f0);

  // NOTE: combinational block uses blocking assignments with defaults first, so no latches form.
  always_comb begin
    grant0  = 1'b0;
    grant1  = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      PRIO_HI: begin
        if (elig1 && (cnt_q < WMAX || !elig0)) begin
          grant1 = 1'b1;
          cnt_d  = (cnt_q == WMAX) ? cnt_q : cnt_q + 1'b1;
          if (cnt_d == WMAX && elig0) state_d = PRIO_LO;
        end else if (elig0) begin
          grant0 = 1'b1;
          cnt_d  = '0;
        end
      end
      PRIO_LO: begin
        if (elig0)      grant0 = 1'b1;
        else if (elig1) grant1 = 1'b1;
        if (elig0 || elig1) begin
          state_d = PRIO_HI;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = PRIO_HI;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= PRIO_HI;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_q | err_f0 | err_f1;
    end
  end

  // Pops are gated by reset so upstream sees none while reset is held.
  assign bus.in0_pop = grant0 & reset;
  assign bus.in1_pop = grant1 & reset;
  assign bus.Error   = err_q;

  assign din_f   = grant1 ? bus.in1 : bus.in0;
  assign push_f0 = (grant0 & ~dest0) | (grant1 & ~dest1);
  assign push_f1 = (grant0 &  dest0) | (grant1 &  dest1);

  dest_fifo #(
    .DATA_SIZE(DATA_SIZE), .DEPTH(FIFO_DEPTH),
    .AF_THRESH(AF_THRESH), .AE_THRESH(AE_THRESH)
  ) u_fifo0 (
    .clk         (clk),
    .rst_n       (reset),
    .push        (push_f0),
    .din         (din_f),
    .pop         (bus.pop0),
    .dout        (bus.out0),
    .empty       (bus.empty0),
    .full        (full_f0),
    .almost_full (bus.almost_full0),
    .almost_empty(bus.almost_empty0),
    .err         (err_f0)
  );

  dest_fifo #(
    .DATA_SIZE(DATA_SIZE), .DEPTH(FIFO_DEPTH),
    .AF_THRESH(AF_THRESH), .AE_THRESH(AE_THRESH)
  ) u_fifo1 (
    .clk         (clk),
    .rst_n       (reset),
    .push        (push_f1),
    .din         (din_f),
    .pop         (bus.pop1),
    .dout        (bus.out1),
    .empty       (bus.empty1),
    .full        (full_f1),
    .almost_full (bus.almost_full1),
    .almost_empty(bus.almost_empty1),
    .err         (err_f1)
  );

  assign bus.full0 = full_f0;
  assign bus.full1 = full_f1;

endmodule

// File: tb/tb_dest_switching.sv
// Self-checking bench: directed scenarios plus random traffic, compared each
// cycle against a queue-based model of upstream FIFOs, arbiter and outputs.
module tb_dest_switching;
  localparam int DS    = 10;
  localparam int DEPTH = 4;
  typedef logic [DS-1:0] word_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dest_switching_if #(.DATA_SIZE(DS)) bus ();

  dest_switching #(
    .DATA_SIZE(DS), .FIFO_DEPTH(DEPTH), .AF_THRESH(3), .AE_THRESH(1), .WEIGHT(3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  word_t up0[$], up1[$], mq0[$], mq1[$];
  int    streak;
  bit    owe0;
  bit    m_err;
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic word_t mk(input bit cls, input bit d);
    word_t w;
    w = word_t'($urandom);
    w[DS-1] = cls;
    w[DS-2] = d;
    return w;
  endfunction

  function automatic bit dest_full(input word_t w);
    return (w[DS-2] ? mq1.size() : mq0.size()) >= DEPTH;
  endfunction

  function automatic void model_grant(output bit g0, output bit g1, output bit e0);
    bit e1;
    e0 = (up0.size() != 0) && !dest_full(up0[0]);
    e1 = (up1.size() != 0) && !dest_full(up1[0]);
    g0 = 1'b0;
    g1 = 1'b0;
    if (owe0) begin
      if (e0)      g0 = 1'b1;
      else if (e1) g1 = 1'b1;
    end else if (e1 && (streak < 3 || !e0)) g1 = 1'b1;
    else if (e0) g0 = 1'b1;
  endfunction

  function automatic void model_reset();
    mq0.delete();
    mq1.delete();
    streak = 0;
    owe0   = 1'b0;
    m_err  = 1'b0;
  endfunction

  function automatic void model_edge(input bit g0, input bit g1, input bit e0,
                                     input bit p0, input bit p1);
    word_t w;
    if (owe0) begin
      if (g0 || g1) begin owe0 = 1'b0; streak = 0; end
    end else if (g1) begin
      if (streak < 3) streak++;
      if (streak == 3 && e0) owe0 = 1'b1;
    end else if (g0) streak = 0;
    if (p0) begin if (mq0.size() != 0) void'(mq0.pop_front()); else m_err = 1'b1; end
    if (p1) begin if (mq1.size() != 0) void'(mq1.pop_front()); else m_err = 1'b1; end
    if (g0 || g1) begin
      w = g0 ? up0.pop_front() : up1.pop_front();
      if (w[DS-2]) mq1.push_back(w); else mq0.push_back(w);
    end
  endfunction

  task automatic drive(input bit p0, input bit p1);
    bus.in0       = (up0.size() != 0) ? up0[0] : '0;
    bus.in0_empty = (up0.size() == 0);
    bus.in1       = (up1.size() != 0) ? up1[0] : '0;
    bus.in1_empty = (up1.size() == 0);
    bus.pop0      = p0;
    bus.pop1      = p1;
  endtask

  // Entered 1 time unit after a rising edge; checks mid-cycle, then advances.
  task automatic cycle(input bit p0, input bit p1, output bit o0, output bit o1);
    bit g0, g1, e0;
    drive(p0, p1);
    #3;
    model_grant(g0, g1, e0);
    o0 = bus.in0_pop;
    o1 = bus.in1_pop;
    check("in0_pop", 32'(bus.in0_pop), 32'(g0));
    check("in1_pop", 32'(bus.in1_pop), 32'(g1));
    check("out0", 32'(bus.out0), (mq0.size() != 0) ? 32'(mq0[0]) : 32'd0);
    check("out1", 32'(bus.out1), (mq1.size() != 0) ? 32'(mq1[0]) : 32'd0);
    check("empty0", 32'(bus.empty0), 32'(mq0.size() == 0));
    check("empty1", 32'(bus.empty1), 32'(mq1.size() == 0));
    check("full0", 32'(bus.full0), 32'(mq0.size() == DEPTH));
    check("full1", 32'(bus.full1), 32'(mq1.size() == DEPTH));
    check("almost_full0", 32'(bus.almost_full0), 32'(mq0.size() >= 3));
    check("almost_full1", 32'(bus.almost_full1), 32'(mq1.size() >= 3));
    check("almost_empty0", 32'(bus.almost_empty0), 32'(mq0.size() <= 1));
    check("almost_empty1", 32'(bus.almost_empty1), 32'(mq1.size() <= 1));
    check("Error", 32'(bus.Error), 32'(m_err));
    @(posedge clk);
    model_edge(g0, g1, e0, p0, p1);
    #1;
  endtask

  task automatic reset_checks(input string pfx);
    check({pfx, "_in0_pop"}, 32'(bus.in0_pop), 0);
    check({pfx, "_in1_pop"}, 32'(bus.in1_pop), 0);
    check({pfx, "_out0"}, 32'(bus.out0), 0);
    check({pfx, "_out1"}, 32'(bus.out1), 0);
    check({pfx, "_empty0"}, 32'(bus.empty0), 1);
    check({pfx, "_empty1"}, 32'(bus.empty1), 1);
    check({pfx, "_full0"}, 32'(bus.full0), 0);
    check({pfx, "_full1"}, 32'(bus.full1), 0);
    check({pfx, "_af0"}, 32'(bus.almost_full0), 0);
    check({pfx, "_af1"}, 32'(bus.almost_full1), 0);
    check({pfx, "_ae0"}, 32'(bus.almost_empty0), 1);
    check({pfx, "_ae1"}, 32'(bus.almost_empty1), 1);
    check({pfx, "_Error"}, 32'(bus.Error), 0);
  endtask

  task automatic drain(input int budget);
    bit o0, o1;
    int n = 0;
    while ((up0.size() + up1.size() + mq0.size() + mq1.size()) != 0 && n < budget) begin
      cycle(mq0.size() != 0, mq1.size() != 0, o0, o1);
      n++;
    end
    check("drain_done", 32'(up0.size() + up1.size() + mq0.size() + mq1.size()), 0);
  endtask

  task automatic random_traffic(input int n);
    bit o0, o1;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 2) != 0 && up0.size() < 6) up0.push_back(mk(1'b0, 1'($urandom)));
      if ($urandom_range(0, 2) != 0 && up1.size() < 6) up1.push_back(mk(1'b1, 1'($urandom)));
      cycle(1'($urandom), 1'($urandom), o0, o1);
    end
  endtask

  initial begin
    bit o0, o1;
    int n0;

    model_reset();
    reset = 1'b0;
    up0.push_back(mk(1'b0, 1'b1));
    up1.push_back(mk(1'b1, 1'b0));
    drive(1'b0, 1'b0);
    #2;
    reset_checks("por");
    up0.delete();
    up1.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Routing: class order preserved per destination.
    up1.push_back(10'h300);
    up1.push_back(10'h200);
    up0.push_back(10'h155);
    up0.push_back(10'h0AB);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, o0, o1);
    #3;
    check("route_out1_first", 32'(bus.out1), 32'h300);
    check("route_out0_first", 32'(bus.out0), 32'h200);
    #0;
    cycle(1'b1, 1'b1, o0, o1);
    check("route_out1_second", 32'(bus.out1), 32'h155);
    check("route_out0_second", 32'(bus.out0), 32'h0AB);
    drain(20);

    // Full/skip: class 1 fills dest 0, class 0 dest-1 word still flows.
    for (int i = 0; i < 4; i++) up1.push_back(mk(1'b1, 1'b0));
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, o0, o1);
    check("fill_full0", 32'(bus.full0), 1);
    check("fill_af0", 32'(bus.almost_full0), 1);
    up1.push_back(mk(1'b1, 1'b0));
    up0.push_back(mk(1'b0, 1'b1));
    cycle(1'b0, 1'b0, o0, o1);
    check("skip_in1_pop", 32'(o1), 0);
    check("skip_in0_pop", 32'(o0), 1);

    // Concurrent push/pop at count 2.
    cycle(1'b1, 1'b0, o0, o1);
    cycle(1'b1, 1'b0, o0, o1);
    cycle(1'b1, 1'b0, o0, o1);
    up1.push_back(mk(1'b1, 1'b0));
    cycle(1'b1, 1'b0, o0, o1);
    check("pushpop_in1_pop", 32'(o1), 1);
    check("pushpop_full0", 32'(bus.full0), 0);
    check("pushpop_af0", 32'(bus.almost_full0), 0);
    check("pushpop_ae0", 32'(bus.almost_empty0), 0);
    drain(20);

    // WRR: both classes always eligible -> class 0 gets 1 of every 4 grants.
    for (int i = 0; i < 20; i++) begin
      up0.push_back(mk(1'b0, 1'($urandom)));
      up1.push_back(mk(1'b1, 1'($urandom)));
    end
    n0 = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(mq0.size() != 0, mq1.size() != 0, o0, o1);
      if (o0) n0++;
    end
    check("wrr_class0_grants", 32'(n0), 4);
    drain(60);

    // Error: pop of empty destination 1 is sticky.
    cycle(1'b0, 1'b1, o0, o1);
    #3;
    check("err_set", 32'(bus.Error), 1);
    #0;
    random_traffic(150);
    check("err_sticky", 32'(bus.Error), 1);

    // Reset mid-traffic: takes effect without a clock edge.
    up0.push_back(mk(1'b0, 1'b0));
    up1.push_back(mk(1'b1, 1'b1));
    cycle(1'b0, 1'b0, o0, o1);
    up0.push_back(mk(1'b0, 1'b1));
    up1.push_back(mk(1'b1, 1'b0));
    drive(1'b0, 1'b0);
    #1;
    reset = 1'b0;
    #1;
    reset_checks("mid");
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    random_traffic(150);
    drain(60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dest_switching.md
Name: dest_switching

Overview:
- Destination-switching layer directly downstream of the class-switching layer.
- Takes the heads of the two class FIFOs (class 0, class 1) and arbitrates between them with weighted round-robin favouring class 1.
- Routes each granted word by its destination bit into one of two output FIFOs.
- Exports full/almost-full/almost-empty flags for dataflow control.

Parameters:
- DATA_SIZE, 10, word width; bit DATA_SIZE-1 = class, bit DATA_SIZE-2 = destination.
- FIFO_DEPTH, 4, entries per output FIFO; must be a power of two.
- AF_THRESH, 3, almost_full asserts when count >= AF_THRESH.
- AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH.
- WEIGHT, 3, maximum consecutive class-1 grants while class 0 is waiting.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in0  in  DATA_SIZE  head word of the class-0 FIFO; valid when in0_empty=0.
- in0_empty  in  1  class-0 FIFO empty.
- in0_pop  out  1  consume the in0 head at the next edge.
- in1  in  DATA_SIZE  head word of the class-1 FIFO.
- in1_empty  in  1  class-1 FIFO empty.
- in1_pop  out  1  consume the in1 head.
- out0  out  DATA_SIZE  head of destination-0 FIFO; 0 when empty0=1.
- out1  out  DATA_SIZE  head of destination-1 FIFO; 0 when empty1=1.
- pop0  in  1  downstream pop of destination-0 FIFO.
- pop1  in  1  downstream pop of destination-1 FIFO.
- empty0, empty1  out  1 each  output FIFO empty.
- full0, full1  out  1 each  output FIFO full.
- almost_full0, almost_full1  out  1 each  count >= AF_THRESH.
- almost_empty0, almost_empty1  out  1 each  count <= AE_THRESH.
- Error  out  1  sticky error flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - in*_pop=0, out*=0, empty*=1, full*=0, almost_full*=0, almost_empty*=1, Error=0.
  - FSM goes to PRIO_HI with burst count 0; FIFO pointers and counts go to 0; stored contents are discarded.
  - Asserting reset mid-traffic takes effect immediately, with no clock edge.
- Eligibility: class k is eligible when in_k_empty=0 and full_d=0, where d = in_k[DATA_SIZE-2].
  - full is the registered-count flag. A downstream pop in the same cycle does not free space for a push; there is no combinational path from pop* to in*_pop.
- FSM states: PRIO_HI and PRIO_LO. Burst counter width is clog2(WEIGHT+1).
  - In PRIO_HI:
    - If class 1 is eligible and (count < WEIGHT or class 0 is not eligible): grant class 1 and count++, saturating at WEIGHT.
    - Else if class 0 is eligible: grant class 0, set count=0, stay in PRIO_HI.
    - When count reaches WEIGHT and class 0 is eligible, go to PRIO_LO.
  - In PRIO_LO:
    - Grant class 0 if eligible, otherwise grant class 1.
    - After any grant, go to PRIO_HI with count=0.
  - If neither class is eligible: no grant, and state and count hold.
  - Skip rule: a class blocked by its destination FIFO never stalls the other class.
- Grants are combinational:
  - in_k_pop = grant_k. At most one grant per cycle, so at most one push per output FIFO per cycle.
  - The granted word is written into FIFO d at the same edge that pops it upstream. Latency from in_k to out_d is 1 cycle when FIFO d was empty.
- Output FIFOs:
  - Show-ahead; out_d = mem[rd_ptr] whenever count > 0.
  - Pointers wrap modulo FIFO_DEPTH.
  - Push and pop in the same cycle on a non-empty FIFO leave count unchanged and preserve order.
  - A push always targets a non-full FIFO; pushing into a full FIFO is unreachable by construction.
- Flags are derived from the registered count and update the cycle after the edge that changes it.
- Error:
  - Set when pop_d=1 while empty_d=1; that pop is ignored.
  - Stays at 1 until reset.
- Word content is passed unmodified.

Decomposition:
- Shared package holds:
  - CLASS_BIT = DATA_SIZE-1 and DEST_BIT = DATA_SIZE-2.
  - State encoding PRIO_HI=1'b0, PRIO_LO=1'b1.
  - Default DATA_SIZE and FIFO_DEPTH.
- One sub-module, dest_fifo: synchronous show-ahead FIFO with count, full, empty, almost_full, almost_empty and pop-on-empty error.
  - Instantiated twice; dest_switching ORs the two error outputs into the sticky Error flag.
- Arbiter FSM and routing stay in the top level.

Test Plan:
- Reset test: drive traffic, then drop reset to 0 mid-cycle -> all outputs reach reset values with no edge; after release, empty0=empty1=1 and Error=0.
- Routing test: push in1=10'h300 and 10'h200, and in0=10'h155 and 10'h0AB, with pop0=pop1=0 -> out1 shows 10'h300, then 10'h155; out0 shows 10'h200, then 10'h0AB; class order is preserved within each destination.
- WRR test: both class FIFOs continuously non-empty, pop0=pop1=1 held -> grant sequence 1,1,1,0 repeats; class 0 gets exactly 1 of every 4 grants.
- Full/skip test: pop0=0 and class 1 sends only dest-0 words -> almost_full0=1 after the 3rd push, full0=1 after the 4th; in1_pop then stays 0 while a class-0 dest-1 word is still granted on the next cycle.
- Concurrent push/pop test: FIFO 0 at count 2, push and pop0 in the same cycle -> count stays 2, full0=0, and out0 sequence matches FIFO order.
- Error test: pop1=1 while empty1=1 -> Error=1 the next cycle; it stays 1 under further traffic until reset=0.
